// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern sequencer: channel play modes and reset pattern.
// Pure declarations; no timing or flow-control behaviour.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_LOOP    = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_e;

  localparam logic [31:0] PAT_DEFAULT_C = 32'h0000_3C05;

endpackage

// File: rtl/led_pattern_channel.sv
// One LED channel: stores pattern/len/mode/idx and advances on the shared step tick.
// LED is registered (1 cycle from state); config is accepted unconditionally, no backpressure.
module led_pattern_channel
  import led_pattern_pkg::*;
#(
  parameter int              PAT_W       = 32,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = '0,
  localparam int             IW          = $clog2(PAT_W),
  localparam int             LW          = $clog2(PAT_W) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_step_tick,
  input  logic             i_sync,
  input  logic             i_wr_en,
  input  logic [PAT_W-1:0] i_cfg_pattern,
  input  logic [LW-1:0]    i_cfg_len,
  input  mode_e            i_cfg_mode,
  output logic             o_led,
  output logic             o_busy
);

  logic [PAT_W-1:0] r_pattern;
  logic [LW-1:0]    r_len;
  mode_e            r_mode;
  logic [IW-1:0]    r_idx;
  logic             r_led;
  logic             r_busy;

  logic w_last;
  logic w_led_nxt;

  // r_len is always 1..PAT_W, so len-1 never underflows
  assign w_last = ({1'b0, r_idx} == (r_len - LW'(1)));

  always_comb begin
    w_led_nxt = 1'b0;
    case (r_mode)
      MODE_OFF:     w_led_nxt = 1'b0;
      MODE_ON:      w_led_nxt = 1'b1;
      MODE_LOOP:    w_led_nxt = r_pattern[r_idx];
      MODE_ONESHOT: w_led_nxt = r_pattern[r_idx];
      default:      w_led_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pattern <= PAT_DEFAULT;
      r_len     <= LW'(PAT_W);
      r_mode    <= MODE_LOOP;
      r_idx     <= '0;
      r_led     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_led <= w_led_nxt;
      // A write beats sync, and sync beats a step advance in the same cycle
      if (i_wr_en) begin
        r_pattern <= i_cfg_pattern;
        r_len     <= i_cfg_len;
        r_mode    <= i_cfg_mode;
        r_idx     <= '0;
        r_busy    <= (i_cfg_mode == MODE_ONESHOT);
      end else if (i_sync) begin
        r_idx <= '0;
      end else if (i_step_tick) begin
        case (r_mode)
          MODE_LOOP: begin
            r_idx <= w_last ? '0 : r_idx + IW'(1);
          end
          MODE_ONESHOT: begin
            if (w_last) begin
              r_mode <= MODE_OFF;
              r_busy <= 1'b0;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
          default: begin
            r_idx <= r_idx;
          end
        endcase
      end
    end
  end

  assign o_led  = r_led;
  assign o_busy = r_busy;

endmodule

// File: rtl/led_pattern_sequencer.sv
// Multi-channel LED pattern engine: shared step prescaler, config decode/len clamp, channels.
// LED registered 1 cycle after state; cfg_ready follows RST_N, so writes never stall.
module led_pattern_sequencer
  import led_pattern_pkg::*;
#(
  parameter int               NUM_CH      = 3,
  parameter int               PAT_W       = 32,
  parameter int               PRESCALE    = 2097152,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(PAT_DEFAULT_C),
  localparam int              CHW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int              LW          = $clog2(PAT_W) + 1,
  localparam int              PSW         = $clog2(PRESCALE)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CHW-1:0]    cfg_ch,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [LW-1:0]     cfg_len,
  input  logic [1:0]        cfg_mode,
  input  logic              sync,
  output logic [NUM_CH-1:0] LED,
  output logic [NUM_CH-1:0] busy,
  output logic              USBPU
);

  logic [PSW-1:0]    r_presc;
  logic              w_step_tick;
  logic              w_cfg_fire;
  logic [LW-1:0]     w_cfg_len;
  logic [NUM_CH-1:0] w_led;
  logic [NUM_CH-1:0] w_busy;

  assign cfg_ready   = RST_N;
  assign w_cfg_fire  = cfg_valid && cfg_ready;
  assign w_step_tick = (r_presc == PSW'(PRESCALE - 1));

  // Zero or over-long lengths play the full pattern
  assign w_cfg_len = ((cfg_len == '0) || (cfg_len > LW'(PAT_W))) ? LW'(PAT_W) : cfg_len;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_presc <= '0;
    end else if (sync || w_step_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PSW'(1);
    end
  end

  // Out-of-range cfg_ch matches no channel, so the write is silently dropped
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic w_wr_en;
    assign w_wr_en = w_cfg_fire && (cfg_ch == CHW'(g));

    led_pattern_channel #(
      .PAT_W       (PAT_W),
      .PAT_DEFAULT (PAT_DEFAULT)
    ) u_channel (
      .i_clk         (CLK),
      .i_rst_n       (RST_N),
      .i_step_tick   (w_step_tick),
      .i_sync        (sync),
      .i_wr_en       (w_wr_en),
      .i_cfg_pattern (cfg_pattern),
      .i_cfg_len     (w_cfg_len),
      .i_cfg_mode    (mode_e'(cfg_mode)),
      .o_led         (w_led[g]),
      .o_busy        (w_busy[g])
    );
  end

  assign LED   = w_led;
  assign busy  = w_busy;
  assign USBPU = 1'b0;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer (NUM_CH=3, PAT_W=8, PRESCALE=4): cycle scoreboard plus
// hand-derived step sequences for the directed scenarios.
module tb_led_pattern_sequencer;

  localparam int NCH = 3;
  localparam int PW  = 8;
  localparam int PS  = 4;

  localparam logic [1:0] M_OFF     = 2'd0;
  localparam logic [1:0] M_ON      = 2'd1;
  localparam logic [1:0] M_LOOP    = 2'd2;
  localparam logic [1:0] M_ONESHOT = 2'd3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [1:0]     cfg_ch = '0;
  logic [PW-1:0]  cfg_pattern = '0;
  logic [3:0]     cfg_len = '0;
  logic [1:0]     cfg_mode = '0;
  logic           sync = 1'b0;
  logic [NCH-1:0] led;
  logic [NCH-1:0] busy;
  logic           usbpu;

  always #5 clk = ~clk;

  led_pattern_sequencer #(
    .NUM_CH   (NCH),
    .PAT_W    (PW),
    .PRESCALE (PS)
  ) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_mode    (cfg_mode),
    .sync        (sync),
    .LED         (led),
    .busy        (busy),
    .USBPU       (usbpu)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
  endtask

  // Reference state, updated once per clock edge from the inputs driven for that edge
  typedef struct packed {
    logic [NCH-1:0] led;
    logic [NCH-1:0] busy;
    logic           rdy;
  } exp_t;

  exp_t       sb_q[$];
  int         m_p;
  logic [7:0] m_pat  [NCH];
  int         m_len  [NCH];
  logic [1:0] m_mode [NCH];
  int         m_idx  [NCH];
  logic       m_busy [NCH];
  logic       m_led  [NCH];

  task automatic model_step();
    exp_t e;
    bit   tk;
    if (!rst_n) begin
      m_p = 0;
      for (int c = 0; c < NCH; c++) begin
        m_pat[c] = 8'h05; m_len[c] = PW; m_mode[c] = M_LOOP;
        m_idx[c] = 0; m_busy[c] = 1'b0; m_led[c] = 1'b0;
      end
    end else begin
      tk = (m_p == PS - 1);
      for (int c = 0; c < NCH; c++) begin
        if (m_mode[c] == M_OFF) m_led[c] = 1'b0;
        else if (m_mode[c] == M_ON) m_led[c] = 1'b1;
        else m_led[c] = m_pat[c][m_idx[c]];
      end
      for (int c = 0; c < NCH; c++) begin
        if (cfg_valid && int'(cfg_ch) == c) begin
          m_pat[c]  = cfg_pattern;
          m_len[c]  = (cfg_len == 0 || int'(cfg_len) > PW) ? PW : int'(cfg_len);
          m_mode[c] = cfg_mode;
          m_idx[c]  = 0;
          m_busy[c] = (cfg_mode == M_ONESHOT);
        end else if (sync) begin
          m_idx[c] = 0;
        end else if (tk) begin
          if (m_mode[c] == M_LOOP) begin
            m_idx[c] = (m_idx[c] == m_len[c] - 1) ? 0 : m_idx[c] + 1;
          end else if (m_mode[c] == M_ONESHOT) begin
            if (m_idx[c] < m_len[c] - 1) m_idx[c]++;
            else begin m_mode[c] = M_OFF; m_busy[c] = 1'b0; end
          end
        end
      end
      m_p = (sync || tk) ? 0 : m_p + 1;
    end
    for (int c = 0; c < NCH; c++) begin
      e.led[c]  = m_led[c];
      e.busy[c] = m_busy[c];
    end
    e.rdy = rst_n;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("led", 32'(led), 32'(e.led));
    chk("busy", 32'(busy), 32'(e.busy));
    chk("cfg_ready", 32'(cfg_ready), 32'(e.rdy));
    chk("usbpu", 32'(usbpu), 32'd0);
  endtask

  task automatic cfg_go(input int ch, input logic [7:0] pat, input logic [3:0] len,
                        input logic [1:0] mode, input logic s);
    cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_pattern = pat;
    cfg_len = len; cfg_mode = mode; sync = s;
    tick();
    cfg_valid = 1'b0; sync = 1'b0;
  endtask

  // Samples one channel once per step, starting the edge after an anchor (reset/sync/tick)
  task automatic capture(input int ch, input int n, output logic [15:0] lq, output logic [15:0] bq);
    lq = '0; bq = '0;
    for (int k = 0; k < n; k++) begin
      tick();
      lq[k] = led[ch];
      bq[k] = busy[ch];
      repeat (PS - 1) tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] lq, bq;

    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    rst_n = 1'b1;
    capture(0, 8, lq, bq);
    chk("ch0_default_seq", 32'(lq[7:0]), 32'h05);

    cfg_go(1, 8'b0000_0110, 4'd3, M_LOOP, 1'b1);
    capture(1, 6, lq, bq);
    chk("ch1_len3_loop", 32'(lq[5:0]), 32'b110110);

    cfg_go(2, 8'hFF, 4'd2, M_ONESHOT, 1'b1);
    chk("ch2_busy_at_wr", 32'(busy[2]), 32'd1);
    capture(2, 4, lq, bq);
    chk("ch2_oneshot_led", 32'(lq[3:0]), 32'b0011);
    chk("ch2_oneshot_busy", 32'(bq[3:0]), 32'b0011);

    sync = 1'b1; tick(); sync = 1'b0;
    capture(2, 2, lq, bq);
    chk("ch2_off_after_sync", 32'({bq[1:0], lq[1:0]}), 32'd0);

    sync = 1'b1; tick(); sync = 1'b0;
    repeat (PS - 1) tick();
    cfg_go(0, 8'b0000_0010, 4'd8, M_LOOP, 1'b0);
    capture(0, 2, lq, bq);
    chk("ch0_cfg_beats_tick", 32'(lq[1:0]), 32'b10);

    cfg_go(3, 8'hFF, 4'd8, M_ON, 1'b1);
    capture(0, 2, lq, bq);
    chk("bad_ch_dropped", 32'(lq[1:0]), 32'b10);

    cfg_go(1, 8'h81, 4'd0, M_LOOP, 1'b1);
    capture(1, 9, lq, bq);
    chk("len0_clamp", 32'(lq[8:0]), 32'h181);
    cfg_go(1, 8'h81, 4'd15, M_LOOP, 1'b1);
    capture(1, 9, lq, bq);
    chk("len15_clamp", 32'(lq[8:0]), 32'h181);

    cfg_go(1, 8'hFE, 4'd1, M_LOOP, 1'b1);
    capture(1, 3, lq, bq);
    chk("len1_loop_hold", 32'(lq[2:0]), 32'd0);
    cfg_go(2, 8'hFF, 4'd1, M_ONESHOT, 1'b1);
    capture(2, 2, lq, bq);
    chk("len1_oneshot_led", 32'(lq[1:0]), 32'b01);
    chk("len1_oneshot_busy", 32'(bq[1:0]), 32'b01);

    cfg_go(2, 8'hFF, 4'd8, M_ONESHOT, 1'b1);
    repeat (6) tick();
    chk("midrst_busy_before", 32'(busy[2]), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("midrst_led", 32'(led), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    capture(2, 3, lq, bq);
    chk("midrst_default_led", 32'(lq[2:0]), 32'b101);
    chk("midrst_default_busy", 32'(bq[2:0]), 32'd0);

    for (int i = 0; i < 400; i++) begin
      cfg_valid   = ($urandom_range(0, 5) == 0);
      cfg_ch      = 2'($urandom_range(0, 3));
      cfg_pattern = 8'($urandom);
      cfg_len     = 4'($urandom_range(0, 15));
      cfg_mode    = 2'($urandom_range(0, 3));
      sync        = ($urandom_range(0, 19) == 0);
      tick();
    end
    cfg_valid = 1'b0; sync = 1'b0;
    repeat (2 * PS) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
